// File: rtl/mux_arb_n.sv
// ============================================================================
// Module   : mux_arb_n
// Purpose  : N-channel, W-bit registered data selector with a round-robin
//            arbiter (request/grant), bounded bus lock and a direct-select
//            bypass mode.
// Revision : 1.0 - initial release
//
// Ports
//   CLK       in   1               system clock, rising edge
//   RESETL    in   1               asynchronous active-low reset
//   MODE      in   1               0 = arbitrated, 1 = direct select
//   SEL       in   CHANNELS        direct-mode select (multi-hot allowed)
//   REQ       in   CHANNELS        per-channel request (arbitrated mode)
//   LOCK      in   CHANNELS        per-channel lock, qualified by own REQ
//   IN        in   CHANNELS*WIDTH  channel k data at [k*WIDTH +: WIDTH]
//   GNT       out  CHANNELS        registered one-hot grant
//   OUT       out  WIDTH           registered muxed data
//   VALID     out  1               OUT carries granted/selected data
//   CONFLICT  out  1               sticky: direct mode saw >1 SEL bit
// ============================================================================
`default_nettype none

module mux_arb_n #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic                      CLK,
  input  logic                      RESETL,
  input  logic                      MODE,
  input  logic [CHANNELS-1:0]       SEL,
  input  logic [CHANNELS-1:0]       REQ,
  input  logic [CHANNELS-1:0]       LOCK,
  input  logic [CHANNELS*WIDTH-1:0] IN,
  output logic [CHANNELS-1:0]       GNT,
  output logic [WIDTH-1:0]          OUT,
  output logic                      VALID,
  output logic                      CONFLICT
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(CHANNELS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;       // last winner; equals owner in OWN
  logic [CNT_W-1:0]   cnt, cnt_nxt;       // hold counter for a locked owner
  logic [CHANNELS-1:0] gnt_nxt;
  logic [WIDTH-1:0]   out_nxt;
  logic               valid_nxt;
  logic               conflict_nxt;

  logic [WIDTH-1:0]   chan [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign chan[k] = IN[k*WIDTH +: WIDTH];
  end

  // Round-robin scan starting one past the pointer. The current owner is
  // visited last, so on a timeout any other requester wins before it.
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      scan_idx = PTR_W'((int'(ptr) + i) % CHANNELS);
      if (!win_found && REQ[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Direct-mode AND-OR tree; unselected channels are masked to zero.
  logic [WIDTH-1:0]   dir_data;

  always_comb begin
    dir_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      dir_data = dir_data | (chan[k] & {WIDTH{SEL[k]}});
    end
  end

  logic [CHANNELS-1:0] own_oh;
  logic                other_req;
  logic                owner_keep;
  logic                sel_multi;

  assign own_oh     = CHANNELS'(1) << ptr;
  assign other_req  = |(REQ & ~own_oh);
  assign owner_keep = REQ[ptr] & LOCK[ptr] & (cnt < MAX_CNT);
  assign sel_multi  = |(SEL & (SEL - CHANNELS'(1)));

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    gnt_nxt      = '0;
    out_nxt      = OUT;
    valid_nxt    = 1'b0;
    conflict_nxt = CONFLICT;

    if (MODE) begin
      // Arbiter frozen: pointer and counter hold, any ownership is dropped.
      state_nxt    = IDLE;
      out_nxt      = dir_data;
      valid_nxt    = |SEL;
      conflict_nxt = CONFLICT | sel_multi;
    end else if (state == OWN && owner_keep) begin
      gnt_nxt   = own_oh;
      out_nxt   = chan[ptr];
      valid_nxt = 1'b1;
      // owner_keep guarantees cnt < MAX_CNT, so the increment cannot wrap;
      // reaching MAX_CNT forces rearbitration on the following edge.
      cnt_nxt   = other_req ? cnt + 1'b1 : '0;
    end else if (win_found) begin
      // Covers IDLE grants and every rearbitration out of OWN, with the
      // new owner taking effect on this same edge.
      state_nxt = OWN;
      ptr_nxt   = win_idx;
      cnt_nxt   = '0;
      gnt_nxt   = CHANNELS'(1) << win_idx;
      out_nxt   = chan[win_idx];
      valid_nxt = 1'b1;
    end else begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      cnt      <= '0;
      GNT      <= '0;
      OUT      <= '0;
      VALID    <= 1'b0;
      CONFLICT <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      GNT      <= gnt_nxt;
      OUT      <= out_nxt;
      VALID    <= valid_nxt;
      CONFLICT <= conflict_nxt;
    end
  end

endmodule

`default_nettype wire

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised N-channel, W-bit successor to the two-input AND-OR select mux.
- Adds a registered output, a round-robin arbiter with request/grant handshake, bus-lock with a bounded hold time, and a direct-select bypass mode.
- Sits between multiple bus masters (CPU, DSP, blitter, video fetch) and a shared data path.
- Registered output replaces the open combinational AND-OR tree.

Parameters:
- CHANNELS, 4, number of input channels (2..8).
- WIDTH, 8, data width per channel.
- MAX_HOLD, 15, max consecutive cycles a locked owner keeps the grant while any other channel requests (1..255).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESETL  in  1  asynchronous active-low reset.
- MODE  in  1  0 = arbitrated, 1 = direct select.
- SEL  in  CHANNELS  direct-mode one-hot (or multi-hot) select.
- REQ  in  CHANNELS  per-channel request, arbitrated mode.
- LOCK  in  CHANNELS  per-channel lock request, qualified by own REQ.
- IN  in  CHANNELS*WIDTH  channel data, channel k at bits [k*WIDTH +: WIDTH].
- GNT  out  CHANNELS  registered one-hot grant.
- OUT  out  WIDTH  registered muxed data.
- VALID  out  1  registered; OUT holds data from a granted or selected source.
- CONFLICT  out  1  sticky; set when direct mode sees more than one SEL bit.

Behaviour:
- Interface: one clock (CLK); reset (RESETL) is asynchronous and active-low.
- Reset (RESETL low, immediate, independent of CLK) clears:
  - GNT=0, OUT=0, VALID=0, CONFLICT=0.
  - Round-robin pointer = CHANNELS-1, so channel 0 has first priority.
  - Hold counter = 0; state = IDLE.
- Reset mid-transfer drops the grant at once. No partial state survives.

Arbitrated mode (MODE=0). States are IDLE and OWN.
- IDLE, no REQ: GNT=0, VALID=0, OUT holds its last value.
- IDLE, any REQ:
  - Winner = first requesting channel scanning upward from pointer+1, wrapping modulo CHANNELS.
  - Next edge: GNT=onehot(winner), OUT=IN[winner] sampled that cycle, VALID=1, pointer=winner, counter=0, go to OWN.
- OWN, owner k:
  - Each edge, OUT reloads IN[k], giving 1-cycle latency from IN to OUT.
  - Counter increments while another REQ is active and saturates at MAX_HOLD. It clears when no other REQ is active.
- OWN, owner keeps the grant when REQ[k]&LOCK[k]=1 and counter<MAX_HOLD.
- OWN, rearbitrate when any of these holds:
  - REQ[k]=0, or
  - LOCK[k]=0, or
  - counter reaches MAX_HOLD.
  - Rearbitration uses the IDLE rule. It excludes k only when the exit is by timeout and another requester exists.
  - The new grant takes effect on the same edge; there is no dead cycle between owners.
  - If no requesters remain, go to IDLE: GNT=0, VALID=0.
- An unlocked owner with other requesters is replaced every cycle; this is pure round-robin.
- An unlocked sole requester is regranted itself every cycle. GNT stays high continuously.

Direct mode (MODE=1):
- Arbiter frozen: pointer and counter hold; GNT=0.
- Next edge: OUT = bitwise OR over k of (IN[k] AND {WIDTH{SEL[k]}}); VALID=|SEL.
- More than one SEL bit set: CONFLICT=1 on that edge. CONFLICT clears only on reset.
- SEL=0: OUT=0, VALID=0.

Mode switching:
- MODE 0->1 while in OWN: grant dropped on the next edge; state becomes IDLE.
- MODE 1->0: arbitration resumes from the held pointer.

Width rules:
- Counter width = clog2(MAX_HOLD+1).
- Pointer width = clog2(CHANNELS).
- No X propagation from unselected channels.

Test Plan:
- Reset: hold RESETL low asynchronously mid-cycle during OWN -> GNT=0, OUT=0, VALID=0 immediately; after release, REQ=4'b0001 -> GNT=0001 next edge.
- Round-robin: CHANNELS=4, REQ=4'b1111 constant, no LOCK -> GNT sequence 0001, 0010, 0100, 1000, 0001; OUT follows IN with 1-cycle latency.
- Lock timeout: MAX_HOLD=3, REQ=1111, LOCK[1]=1 while channel 1 owns -> GNT=0010 for exactly 4 edges, then 0100; with REQ=0010 only, GNT=0010 held indefinitely.
- Release/idle: owner drops REQ with no other requesters -> next edge GNT=0, VALID=0, OUT unchanged; next REQ=1000 granted in one edge.
- Direct mode: MODE=1, IN[0]=8'h0F, IN[2]=8'hF0, SEL=0101 -> OUT=8'hFF, VALID=1, CONFLICT=1 and sticky; SEL=0000 -> OUT=0, VALID=0, CONFLICT stays 1.
- Mode switch: MODE 0->1 during OWN of channel 2 -> GNT=0 next edge; back to MODE=0 with REQ=1111 -> grant goes to channel 3.
